seg_scan_mux: RTL

- Multiplexed scanner for a multi-digit common-anode 7-segment display.
- Sits directly upstream of the per-digit 4-bit-to-segment decoder. Drives the decoder's 4-bit num input and the active-low digit enables.
- Holds a shadow copy of the displayed value. New values are applied only at frame boundaries, so a frame never shows a mix of old and new digits.
- Inserts a blanking gap between digits to suppress ghosting.

---
 rtl/seg_pkg.sv | 25 ++
 rtl/seg_lz_mask.sv | 25 ++
 rtl/seg_scan_mux.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the seg_scan_mux display scanner: blank code, scan states, sizing helper.
package seg_pkg;

  localparam logic [3:0] BLANK_CODE = 4'd10;

  typedef enum logic {
    SHOW = 1'b0,
    GAP  = 1'b1
  } scan_state_t;

  // Ceiling log2 for elaboration-time sizing; clog2(1) is 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int k = 0; k < 31; k++) begin
      if ((32'sd1 <<< k) < n) begin
        r = k + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_lz_mask.sv
// Leading-zero blank mask: bit i set when nibbles DIGITS-1..i of the display value are all zero.
// Digit 0 is never masked so a zero value still shows a single "0".
module seg_lz_mask #(
  parameter int DIGITS = 4
) (
  input  logic [4*DIGITS-1:0] i_disp,
  output logic [DIGITS-1:0]   o_mask
);

  // Walk from the most significant nibble down, accumulating "everything above is zero".
  always_comb begin : lz_walk
    logic zero_above;
    zero_above = 1'b1;
    o_mask     = {DIGITS{1'b0}};
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above & (i_disp[4*i +: 4] == 4'd0);
      if (i > 0) begin
        o_mask[i] = zero_above;
      end else begin
        o_mask[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Multiplexed common-anode 7-segment scanner with frame-synchronous value commit and blanking gaps.
// Define SEG_SCAN_LZB_EN to enable leading-zero blanking.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4*DIGITS-1:0] value_i,
  input  logic                load_i,
  output logic [3:0]          num_o,
  output logic [DIGITS-1:0]   dig_o,
  output logic                frame_o
);

  localparam int MAX_DB = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
  localparam int TW     = clog2((MAX_DB > 2) ? MAX_DB : 2);
  localparam int IW     = clog2((DIGITS > 2) ? DIGITS : 2);

  localparam logic [TW-1:0] T_ZERO    = {TW{1'b0}};
  localparam logic [TW-1:0] T_ONE     = TW'(1);
  localparam logic [TW-1:0] SHOW_LOAD = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] GAP_LOAD  = TW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [TW-1:0] BOOT_LOAD = TW'((BLANK_CYCLES > 1) ? BLANK_CYCLES - 2 : 0);
  localparam logic [IW-1:0] IDX_ZERO  = {IW{1'b0}};
  localparam logic [IW-1:0] IDX_ONE   = IW'(1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DIGITS - 1);

  scan_state_t         r_state;
  logic [TW-1:0]       r_timer;
  logic [IW-1:0]       r_idx;
  logic                r_boot;
  logic [4*DIGITS-1:0] r_disp;
  logic [4*DIGITS-1:0] r_pend;
  logic                r_pend_vld;
  logic [3:0]          r_num;
  logic [DIGITS-1:0]   r_dig;
  logic                r_frame;

  scan_state_t         w_state_nx;
  logic [TW-1:0]       w_timer_nx;
  logic [IW-1:0]       w_idx_nx;
  logic [IW-1:0]       w_idx_inc;
  logic                w_enter_show;
  logic                w_enter0;
  logic [4*DIGITS-1:0] w_disp_nx;
  logic [4*DIGITS-1:0] w_pend_nx;
  logic                w_pend_vld_nx;
  logic                w_lz_blank;
  logic [3:0]          w_num_nx;
  logic [DIGITS-1:0]   w_dig_nx;

  assign w_idx_inc = (r_idx == LAST_IDX) ? IDX_ZERO : (r_idx + IDX_ONE);
  assign w_enter0  = w_enter_show & (w_idx_nx == IDX_ZERO);

  // The reset GAP has no entry edge, so r_boot stretches it to the full BLANK_CYCLES.
  always_comb begin
    w_state_nx   = r_state;
    w_timer_nx   = r_timer;
    w_idx_nx     = r_idx;
    w_enter_show = 1'b0;
    case (r_state)
      SHOW: begin
        if (r_timer != T_ZERO) begin
          w_timer_nx = r_timer - T_ONE;
        end else if (BLANK_CYCLES == 0) begin
          w_state_nx   = SHOW;
          w_timer_nx   = SHOW_LOAD;
          w_idx_nx     = w_idx_inc;
          w_enter_show = 1'b1;
        end else begin
          w_state_nx = GAP;
          w_timer_nx = GAP_LOAD;
        end
      end
      GAP: begin
        if (r_boot && (BLANK_CYCLES > 1)) begin
          w_timer_nx = BOOT_LOAD;
        end else if (r_timer != T_ZERO) begin
          w_timer_nx = r_timer - T_ONE;
        end else begin
          w_state_nx   = SHOW;
          w_timer_nx   = SHOW_LOAD;
          w_idx_nx     = w_idx_inc;
          w_enter_show = 1'b1;
        end
      end
      default: begin
        w_state_nx = GAP;
        w_timer_nx = T_ZERO;
        w_idx_nx   = LAST_IDX;
      end
    endcase
  end

  // A load on the commit edge bypasses pending so it lands in this frame's digit 0.
  always_comb begin
    w_disp_nx     = r_disp;
    w_pend_nx     = r_pend;
    w_pend_vld_nx = r_pend_vld;
    if (w_enter0) begin
      if (load_i) begin
        w_disp_nx     = value_i;
        w_pend_nx     = value_i;
        w_pend_vld_nx = 1'b0;
      end else if (r_pend_vld) begin
        w_disp_nx     = r_pend;
        w_pend_vld_nx = 1'b0;
      end else begin
        w_disp_nx = r_disp;
      end
    end else if (load_i) begin
      w_pend_nx     = value_i;
      w_pend_vld_nx = 1'b1;
    end else begin
      w_pend_nx = r_pend;
    end
  end

`ifdef SEG_SCAN_LZB_EN
  logic [DIGITS-1:0] w_lz_mask;

  seg_lz_mask #(
    .DIGITS (DIGITS)
  ) u_lz_mask (
    .i_disp (w_disp_nx),
    .o_mask (w_lz_mask)
  );

  assign w_lz_blank = w_lz_mask[w_idx_nx];
`else
  assign w_lz_blank = 1'b0;
`endif

  always_comb begin
    w_num_nx = BLANK_CODE;
    w_dig_nx = {DIGITS{1'b1}};
    if (w_state_nx == SHOW) begin
      w_dig_nx = ~(DIGITS'(1) << w_idx_nx);
      if (w_lz_blank) begin
        w_num_nx = BLANK_CODE;
      end else begin
        w_num_nx = w_disp_nx[4*w_idx_nx +: 4];
      end
    end else begin
      w_num_nx = BLANK_CODE;
    end
  end

  // Outputs are registered from next-state values so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= GAP;
      r_timer    <= T_ZERO;
      r_idx      <= LAST_IDX;
      r_boot     <= 1'b1;
      r_disp     <= {(4*DIGITS){1'b0}};
      r_pend     <= {(4*DIGITS){1'b0}};
      r_pend_vld <= 1'b0;
      r_num      <= BLANK_CODE;
      r_dig      <= {DIGITS{1'b1}};
      r_frame    <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_timer    <= w_timer_nx;
      r_idx      <= w_idx_nx;
      r_boot     <= 1'b0;
      r_disp     <= w_disp_nx;
      r_pend     <= w_pend_nx;
      r_pend_vld <= w_pend_vld_nx;
      r_num      <= w_num_nx;
      r_dig      <= w_dig_nx;
      r_frame    <= w_enter0;
    end
  end

  assign num_o   = r_num;
  assign dig_o   = r_dig;
  assign frame_o = r_frame;

endmodule
